// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding and the oversampling
// ratio agreed with baud_gen.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } uart_rx_state_t;

  localparam int UART_OVERSAMPLE = 16;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous input that idles high.
// Reset loads ones so that no false edge appears when reset is released.
module uart_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled start-bit qualification, centre sampling of
// data/parity/stop, one-cycle valid pulse with frame and parity error flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick_rx,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 rx_busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] HALF_M1  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_M1  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  localparam logic          PAR_EN   = (PARITY_EN != 0);
  localparam logic          PAR_ODD  = (PARITY_ODD != 0);

  logic rx_s;

  uart_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rx),
    .q_o (rx_s)
  );

  uart_rx_state_t       state_q,  state_d;
  logic [TW-1:0]        tick_q,   tick_d;
  logic [BW-1:0]        bit_q,    bit_d;
  logic [DATA_BITS-1:0] shreg_q,  shreg_d;
  logic                 perr_q,   perr_d;
  logic [DATA_BITS-1:0] data_q,   data_d;
  logic                 ferr_q,   ferr_d;
  logic                 parerr_q, parerr_d;
  logic                 valid_q,  valid_d;

  logic centre;
  assign centre = baud_tick_rx && (tick_q == FULL_M1);

  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    perr_d   = perr_q;
    data_d   = data_q;
    ferr_d   = ferr_q;
    parerr_d = parerr_q;
    valid_d  = 1'b0;

    if (baud_tick_rx && (state_q == DATA || state_q == PARITY || state_q == STOP)) begin
      tick_d = centre ? '0 : tick_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          tick_d  = '0;
        end
      end
      START: begin
        // Re-check the line half a bit in so a short glitch is not taken as a frame.
        if (baud_tick_rx) begin
          if (tick_q == HALF_M1) begin
            tick_d = '0;
            if (!rx_s) begin
              state_d = DATA;
              bit_d   = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (centre) begin
          shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
          if (bit_q == LAST_BIT) begin
            state_d = PAR_EN ? PARITY : STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (centre) begin
          perr_d  = ((^shreg_q) ^ rx_s) != PAR_ODD;
          state_d = STOP;
        end
      end
      STOP: begin
        if (centre) begin
          data_d   = shreg_q;
          ferr_d   = ~rx_s;
          parerr_d = PAR_EN & perr_q;
          valid_d  = 1'b1;
          state_d  = rx_s ? IDLE : WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        // A held-low line (break) must return high before a new start is looked for.
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      tick_q   <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      perr_q   <= 1'b0;
      data_q   <= '0;
      ferr_q   <= 1'b0;
      parerr_q <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      perr_q   <= perr_d;
      data_q   <= data_d;
      ferr_q   <= ferr_d;
      parerr_q <= parerr_d;
      valid_q  <= valid_d;
    end
  end

  assign rx_data    = data_q;
  assign rx_valid   = valid_q;
  assign frame_err  = ferr_q;
  assign parity_err = parerr_q;
  assign rx_busy    = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: an 8N1 instance and an 8E1 instance driven from
// a 50 MHz clock with a 115200 baud x16 tick (divide by 27).
module tb_uart_rx;

  localparam int TICK_DIV = 27;
  localparam int BIT_CLKS = TICK_DIV * 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic baud_tick = 1'b0;
  logic rx0 = 1'b1;
  logic rxp = 1'b1;
  int   div_cnt = 0;

  logic [7:0] rx_data0, rx_datap;
  logic       rx_valid0, frame_err0, parity_err0, rx_busy0;
  logic       rx_validp, frame_errp, parity_errp, rx_busyp;

  int n_checks = 0;
  int n_pass   = 0;

  int         vcnt0 = 0;
  int         vcntp = 0;
  logic [7:0] log_data0 [64];
  logic       log_ferr0 [64];

  always #10 clk = ~clk;

  always @(posedge clk) begin
    if (div_cnt == TICK_DIV - 1) begin
      div_cnt   <= 0;
      baud_tick <= 1'b1;
    end else begin
      div_cnt   <= div_cnt + 1;
      baud_tick <= 1'b0;
    end
  end

  uart_rx dut (
    .clk          (clk),
    .rst          (rst),
    .baud_tick_rx (baud_tick),
    .rx           (rx0),
    .rx_data      (rx_data0),
    .rx_valid     (rx_valid0),
    .frame_err    (frame_err0),
    .parity_err   (parity_err0),
    .rx_busy      (rx_busy0)
  );

  uart_rx #(.PARITY_EN(1), .PARITY_ODD(0)) dut_p (
    .clk          (clk),
    .rst          (rst),
    .baud_tick_rx (baud_tick),
    .rx           (rxp),
    .rx_data      (rx_datap),
    .rx_valid     (rx_validp),
    .frame_err    (frame_errp),
    .parity_err   (parity_errp),
    .rx_busy      (rx_busyp)
  );

  always @(negedge clk) begin
    if (rx_valid0) begin
      log_data0[vcnt0 % 64] <= rx_data0;
      log_ferr0[vcnt0 % 64] <= frame_err0;
      vcnt0 <= vcnt0 + 1;
      $display("rx8N1 frame %0d: data=%h frame_err=%b parity_err=%b", vcnt0, rx_data0, frame_err0, parity_err0);
    end
    if (rx_validp) begin
      vcntp <= vcntp + 1;
      $display("rx8E1 frame %0d: data=%h frame_err=%b parity_err=%b", vcntp, rx_datap, frame_errp, parity_errp);
    end
  end

  // Sets the line at a falling edge and holds it for nclk clocks.
  task automatic drive_bit(input bit sel, input logic v, input int nclk);
    if (sel) rxp = v; else rx0 = v;
    repeat (nclk) @(negedge clk);
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] d, input bit par_en,
                            input logic par, input logic stop);
    drive_bit(sel, 1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) drive_bit(sel, d[i], BIT_CLKS);
    if (par_en) drive_bit(sel, par, BIT_CLKS);
    drive_bit(sel, stop, BIT_CLKS);
  endtask

  task automatic test_reset();
    repeat (5) @(negedge clk);
    n_checks++; if (rx_data0 !== 8'h00) $display("FAIL rst_data: got %h want 00", rx_data0); else n_pass++;
    n_checks++; if (rx_valid0 !== 1'b0) $display("FAIL rst_valid: got %b want 0", rx_valid0); else n_pass++;
    n_checks++; if (rx_busy0 !== 1'b0) $display("FAIL rst_busy: got %b want 0", rx_busy0); else n_pass++;
    rst = 1'b1;
    repeat (20) @(negedge clk);
    n_checks++; if (frame_err0 !== 1'b0) $display("FAIL idle_ferr: got %b want 0", frame_err0); else n_pass++;
    n_checks++; if (parity_errp !== 1'b0) $display("FAIL idle_perr: got %b want 0", parity_errp); else n_pass++;
    n_checks++; if (rx_busy0 !== 1'b0) $display("FAIL idle_busy: got %b want 0", rx_busy0); else n_pass++;
    n_checks++; if (vcnt0 !== 0) $display("FAIL idle_nvalid: got %0d want 0", vcnt0); else n_pass++;
  endtask

  task automatic test_basic();
    int n0 = vcnt0;
    send_frame(0, 8'hA5, 0, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    n_checks++; if (vcnt0 !== n0 + 1) $display("FAIL a5_count: got %0d want %0d", vcnt0, n0 + 1); else n_pass++;
    n_checks++; if (rx_data0 !== 8'hA5) $display("FAIL a5_data: got %h want a5", rx_data0); else n_pass++;
    n_checks++; if (frame_err0 !== 1'b0) $display("FAIL a5_ferr: got %b want 0", frame_err0); else n_pass++;
    n_checks++; if (parity_err0 !== 1'b0) $display("FAIL a5_perr: got %b want 0", parity_err0); else n_pass++;
    n_checks++; if (rx_busy0 !== 1'b0) $display("FAIL a5_busy: got %b want 0", rx_busy0); else n_pass++;
  endtask

  task automatic test_glitch();
    int n0 = vcnt0;
    drive_bit(0, 1'b0, 4 * TICK_DIV);
    drive_bit(0, 1'b1, BIT_CLKS);
    n_checks++; if (vcnt0 !== n0) $display("FAIL glitch_count: got %0d want %0d", vcnt0, n0); else n_pass++;
    n_checks++; if (rx_busy0 !== 1'b0) $display("FAIL glitch_busy: got %b want 0", rx_busy0); else n_pass++;
    send_frame(0, 8'h3C, 0, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    n_checks++; if (vcnt0 !== n0 + 1) $display("FAIL glitch_next_count: got %0d want %0d", vcnt0, n0 + 1); else n_pass++;
    n_checks++; if (rx_data0 !== 8'h3C) $display("FAIL glitch_next_data: got %h want 3c", rx_data0); else n_pass++;
    n_checks++; if (frame_err0 !== 1'b0) $display("FAIL glitch_next_ferr: got %b want 0", frame_err0); else n_pass++;
  endtask

  task automatic test_frame_err();
    logic [7:0] d = 8'h3C;
    int n0 = vcnt0;
    drive_bit(0, 1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) drive_bit(0, d[i], BIT_CLKS);
    drive_bit(0, 1'b0, 3 * BIT_CLKS);
    n_checks++; if (vcnt0 !== n0 + 1) $display("FAIL ferr_count: got %0d want %0d", vcnt0, n0 + 1); else n_pass++;
    n_checks++; if (rx_data0 !== 8'h3C) $display("FAIL ferr_data: got %h want 3c", rx_data0); else n_pass++;
    n_checks++; if (frame_err0 !== 1'b1) $display("FAIL ferr_flag: got %b want 1", frame_err0); else n_pass++;
    n_checks++; if (rx_busy0 !== 1'b1) $display("FAIL ferr_busy_low: got %b want 1", rx_busy0); else n_pass++;
    drive_bit(0, 1'b1, 2 * BIT_CLKS);
    n_checks++; if (rx_busy0 !== 1'b0) $display("FAIL ferr_busy_high: got %b want 0", rx_busy0); else n_pass++;
    n_checks++; if (vcnt0 !== n0 + 1) $display("FAIL ferr_spurious: got %0d want %0d", vcnt0, n0 + 1); else n_pass++;
    n_checks++; if (frame_err0 !== 1'b1) $display("FAIL ferr_hold: got %b want 1", frame_err0); else n_pass++;
  endtask

  task automatic test_parity();
    int n0 = vcntp;
    // 0x07 has three ones, so even parity needs a 1 in the parity slot.
    send_frame(1, 8'h07, 1, 1'b1, 1'b1);
    repeat (20) @(negedge clk);
    n_checks++; if (vcntp !== n0 + 1) $display("FAIL par_ok_count: got %0d want %0d", vcntp, n0 + 1); else n_pass++;
    n_checks++; if (rx_datap !== 8'h07) $display("FAIL par_ok_data: got %h want 07", rx_datap); else n_pass++;
    n_checks++; if (parity_errp !== 1'b0) $display("FAIL par_ok_perr: got %b want 0", parity_errp); else n_pass++;
    send_frame(1, 8'h07, 1, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    n_checks++; if (vcntp !== n0 + 2) $display("FAIL par_bad_count: got %0d want %0d", vcntp, n0 + 2); else n_pass++;
    n_checks++; if (parity_errp !== 1'b1) $display("FAIL par_bad_perr: got %b want 1", parity_errp); else n_pass++;
    n_checks++; if (frame_errp !== 1'b0) $display("FAIL par_bad_ferr: got %b want 0", frame_errp); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int n0 = vcnt0;
    send_frame(0, 8'h00, 0, 1'b0, 1'b1);
    send_frame(0, 8'hFF, 0, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    n_checks++; if (vcnt0 !== n0 + 2) $display("FAIL b2b_count: got %0d want %0d", vcnt0, n0 + 2); else n_pass++;
    n_checks++; if (log_data0[n0 % 64] !== 8'h00) $display("FAIL b2b_data0: got %h want 00", log_data0[n0 % 64]); else n_pass++;
    n_checks++; if (log_data0[(n0 + 1) % 64] !== 8'hFF) $display("FAIL b2b_data1: got %h want ff", log_data0[(n0 + 1) % 64]); else n_pass++;
    n_checks++; if (log_ferr0[n0 % 64] !== 1'b0) $display("FAIL b2b_ferr0: got %b want 0", log_ferr0[n0 % 64]); else n_pass++;
    n_checks++; if (log_ferr0[(n0 + 1) % 64] !== 1'b0) $display("FAIL b2b_ferr1: got %b want 0", log_ferr0[(n0 + 1) % 64]); else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d = 8'h5A;
    int n0 = vcnt0;
    drive_bit(0, 1'b0, BIT_CLKS);
    for (int i = 0; i < 4; i++) drive_bit(0, d[i], BIT_CLKS);
    drive_bit(0, d[4], BIT_CLKS / 2);
    rst = 1'b0;
    #1;
    n_checks++; if (rx_data0 !== 8'h00) $display("FAIL mid_rst_data: got %h want 00", rx_data0); else n_pass++;
    n_checks++; if (rx_busy0 !== 1'b0) $display("FAIL mid_rst_busy: got %b want 0", rx_busy0); else n_pass++;
    n_checks++; if (rx_valid0 !== 1'b0) $display("FAIL mid_rst_valid: got %b want 0", rx_valid0); else n_pass++;
    n_checks++; if (rx_datap !== 8'h00) $display("FAIL mid_rst_pdata: got %h want 00", rx_datap); else n_pass++;
    n_checks++; if (parity_errp !== 1'b0) $display("FAIL mid_rst_perr: got %b want 0", parity_errp); else n_pass++;
    rx0 = 1'b1;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    n_checks++; if (vcnt0 !== n0) $display("FAIL mid_rst_novalid: got %0d want %0d", vcnt0, n0); else n_pass++;
    send_frame(0, 8'h5A, 0, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    n_checks++; if (vcnt0 !== n0 + 1) $display("FAIL mid_rst_count: got %0d want %0d", vcnt0, n0 + 1); else n_pass++;
    n_checks++; if (rx_data0 !== 8'h5A) $display("FAIL mid_rst_data_after: got %h want 5a", rx_data0); else n_pass++;
    n_checks++; if (frame_err0 !== 1'b0) $display("FAIL mid_rst_ferr_after: got %b want 0", frame_err0); else n_pass++;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_parity();
    test_back_to_back();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
